// File: rtl/e_mdu_if.sv
// e_mdu_if: request/result bundle between the E-stage controller and the multiply/divide unit.
//   start  - one-cycle request strobe
//   mdop   - operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 reserved
//   A, B   - operands (A is also the move source for mthi/mtlo)
//   busy   - a mult/div is in flight
//   hi, lo - HI/LO architectural registers
interface e_mdu_if;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, mdop, A, B, input busy, hi, lo);
  modport slave  (input start, mdop, A, B, output busy, hi, lo);
endinterface

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit with HI/LO registers.
//   clk   - clock, all state updates on the rising edge
//   reset - synchronous active-high reset; clears hi, lo and any in-flight operation
//   bus   - e_mdu_if slave: start/mdop/A/B request in, busy/hi/lo out
// The full result is computed at the accept edge and held internally; a down-counter models
// the multi-cycle latency and hi/lo are loaded on the edge where the counter reaches zero.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic     clk,
  input logic     reset,
  e_mdu_if.slave  bus
);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  // Cleared for divide-by-zero so completion leaves hi/lo untouched.
  logic        res_wr_q, res_wr_d;

  logic        accept;
  logic        op_signed;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] a_mag, b_mag, div_b, q_mag, r_mag, quot, rem;

  // Signed divide runs on magnitudes so the INT_MIN / -1 case wraps to INT_MIN with
  // remainder 0, and the remainder takes the dividend's sign.
  always_comb begin
    op_signed = (bus.mdop == OpMult) || (bus.mdop == OpDiv);
    a_ext     = {{32{op_signed & bus.A[31]}}, bus.A};
    b_ext     = {{32{op_signed & bus.B[31]}}, bus.B};
    prod      = a_ext * b_ext;
    a_mag     = (op_signed && bus.A[31]) ? (32'd0 - bus.A) : bus.A;
    b_mag     = (op_signed && bus.B[31]) ? (32'd0 - bus.B) : bus.B;
    div_b     = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag     = a_mag / div_b;
    r_mag     = a_mag % div_b;
    quot      = (op_signed && (bus.A[31] ^ bus.B[31])) ? (32'd0 - q_mag) : q_mag;
    rem       = (op_signed && bus.A[31]) ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    accept   = bus.start && !busy_q && (bus.mdop <= OpMtlo);
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_wr_d = res_wr_q;
    if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1 && res_wr_q) begin
        hi_d = res_hi_q;
        lo_d = res_lo_q;
      end
    end else if (accept) begin
      case (bus.mdop)
        OpMult, OpMultu: begin
          res_hi_d = prod[63:32];
          res_lo_d = prod[31:0];
          res_wr_d = 1'b1;
          cnt_d    = 4'(MULT_CYCLES);
        end
        OpDiv, OpDivu: begin
          res_hi_d = rem;
          res_lo_d = quot;
          res_wr_d = (bus.B != 32'd0);
          cnt_d    = 4'(DIV_CYCLES);
        end
        OpMthi:  hi_d = bus.A;
        OpMtlo:  lo_d = bus.A;
        default: ;
      endcase
    end
    busy_d = (cnt_d != 4'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      res_wr_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_wr_q <= res_wr_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy cycles for mult/multu (legal range 1..15).
REQ-002 Parameter DIV_CYCLES, default 10, busy cycles for div/divu (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  request strobe from the E-stage controller, valid for one cycle.
REQ-006 mdop  input  3  operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 reserved.
REQ-007 A  input  32  operand rs, or the move source for mthi/mtlo.
REQ-008 B  input  32  operand rt, ignored for mthi/mtlo.
REQ-009 busy  output  1  high while a mult/div is in flight.
REQ-010 hi  output  32  HI register, registered output.
REQ-011 lo  output  32  LO register, registered output.

Function
REQ-012 The block SHALL accept a request only on an edge where start=1, busy=0 and mdop is 0-5.
REQ-013 start while busy=1, or with mdop 6/7, SHALL be ignored: no state change and no queuing.
REQ-014 mthi/mtlo accepted SHALL write A into hi/lo respectively at that edge; busy stays 0 and the other register is unchanged.
REQ-015 mult/multu/div/divu accepted SHALL latch the full result internally at the accept edge and load a down-counter with MULT_CYCLES or DIV_CYCLES.
REQ-016 busy SHALL equal (counter != 0) and be a registered output.
REQ-017 The counter SHALL decrement by 1 on each edge while nonzero.
REQ-018 On the edge where the counter goes 1 -> 0, hi/lo SHALL load the latched result and busy SHALL fall on that same edge.
REQ-019 Latency is therefore N edges from accept to result visible, with N = MULT_CYCLES or DIV_CYCLES.
REQ-020 A new start SHALL be accepted in the first cycle busy=0, including the cycle immediately after completion.
REQ-021 mult: signed 32x32 -> 64 bits; hi = product[63:32], lo = product[31:0].
REQ-022 multu: same split as mult, with unsigned operands.
REQ-023 div: signed; lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
REQ-024 divu: same assignment as div (lo = quotient, hi = remainder), unsigned.
REQ-025 div/divu with B=0 SHALL run the full DIV_CYCLES busy period and leave hi/lo unchanged at completion.
REQ-026 div with A=0x80000000 and B=0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-027 hi/lo SHALL change only on mthi/mtlo accept, on completion, or on reset.
REQ-028 While busy, hi/lo SHALL hold their pre-operation values.

Reset
REQ-029 reset=1 at an edge SHALL force hi=0, lo=0, counter=0 and busy=0, overriding start.
REQ-030 Reset mid-operation SHALL abort the operation and discard the latched result.
REQ-031 The first start may be accepted on the first edge with reset=0.

Verification
REQ-032 mult A=0xFFFFFFFE, B=3 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-033 div A=0xFFFFFFF9 (-7), B=2 -> busy high for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu A=7, B=2 -> lo=3, hi=1.
REQ-034 mthi A=0x12345678 -> hi=0x12345678 on the next cycle, lo unchanged, busy never rises; start mult while busy -> ignored, first result intact.
REQ-035 div A=5, B=0 with hi=0xAA, lo=0xBB -> busy for 10 cycles, then hi=0xAA, lo=0xBB.
REQ-036 reset asserted on cycle 3 of a div -> hi=0, lo=0, busy=0 on the next cycle; no later update from the aborted div.
REQ-037 Back-to-back: start mult in the first cycle busy=0 after a completing div -> accepted, div result visible, mult result 5 cycles later.
